iir_ff_mac: RTL

- Parametrised multi-tap feed-forward (numerator) section for the configurable IIR filter in the analogue front-end.
- Computes y[n] = sum over k of b[k]*x[n-k], for k = 0..TAPS-1, using one time-shared multiplier.
- Coefficients are double-buffered and programmable at run time.
- Feeds the feedback stage and runs at the sample rate of the acquisition path.

---
 rtl/analogue_pkg.sv | 39 +++
 rtl/iir_coef_bank.sv | 52 +++++
 rtl/iir_ff_mac.sv | 103 ++++++++++
 3 files changed

// File: rtl/analogue_pkg.sv
// Shared definitions for the analogue front-end filter blocks: Q-format
// constants, the feed-forward MAC state encoding and the output
// round/saturate helper.
package analogue_pkg;

  // Default coefficient fraction bits; a coefficient of 1.0 is 2^COEFF_FRAC.
  localparam int COEFF_FRAC_DEFAULT = 14;
  localparam int UNITY_COEF_DEFAULT = 1 << COEFF_FRAC_DEFAULT;

  // Sequencer states of the time-shared MAC.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } ff_state_t;

  // Round half up by 'shift' fraction bits, then clamp to a signed
  // 'out_width' range. Operates on a 64-bit container so callers with any
  // accumulator up to 63 bits can share it; the caller truncates the result.
  function automatic logic signed [63:0] sat_round(
    input logic signed [63:0] value,
    input int                 out_width,
    input int                 shift
  );
    logic signed [63:0] rounded;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    rounded = (value + (64'sd1 <<< (shift - 1))) >>> shift;
    max_v   = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (out_width - 1));
    if (rounded > max_v)
      sat_round = max_v;
    else if (rounded < min_v)
      sat_round = min_v;
    else
      sat_round = rounded;
  endfunction

endpackage

// File: rtl/iir_coef_bank.sv
// Double-buffered coefficient store for the feed-forward MAC. Software
// writes land in the shadow bank; a commit copies shadow to active, deferred
// while a sample is being processed so a sample never sees mixed coefficients.
module iir_coef_bank
  import analogue_pkg::*;
#(
  parameter int TAPS        = 4,
  parameter int COEFF_WIDTH = 16,
  parameter int COEFF_FRAC  = COEFF_FRAC_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          coef_we,
  input  logic [$clog2(TAPS)-1:0]       coef_addr,
  input  logic signed [COEFF_WIDTH-1:0] coef_data,
  input  logic                          coef_commit,
  input  logic                          in_idle,
  input  logic                          accept,
  input  logic [$clog2(TAPS)-1:0]       rd_idx,
  output logic signed [COEFF_WIDTH-1:0] rd_coef
);

  localparam logic signed [COEFF_WIDTH-1:0] UNITY = COEFF_WIDTH'(1) << COEFF_FRAC;

  logic signed [COEFF_WIDTH-1:0] shadow [TAPS];
  logic signed [COEFF_WIDTH-1:0] active [TAPS];
  logic                          commit_pending;

  // Shadow writes, shadow-to-active copy and the deferred-commit flag. The
  // copy reads the pre-write shadow, so a same-cycle write stays in shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        shadow[k] <= (k == 0) ? UNITY : '0;
        active[k] <= (k == 0) ? UNITY : '0;
      end
      commit_pending <= 1'b0;
    end else begin
      if (coef_we && (32'(coef_addr) < TAPS))
        shadow[coef_addr] <= coef_data;
      if (in_idle && (commit_pending || (coef_commit && !accept)))
        active <= shadow;
      if (coef_commit && !(in_idle && !accept))
        commit_pending <= 1'b1;
      else if (in_idle)
        commit_pending <= 1'b0;
    end
  end

  assign rd_coef = active[rd_idx];

endmodule

// File: rtl/iir_ff_mac.sv
// Feed-forward (numerator) section of the configurable IIR filter:
// y[n] = sum b[k]*x[n-k], computed one tap per cycle on a single multiplier.
module iir_ff_mac
  import analogue_pkg::*;
#(
  parameter int PRECISION   = 16,
  parameter int TAPS        = 4,
  parameter int COEFF_WIDTH = 16,
  parameter int COEFF_FRAC  = COEFF_FRAC_DEFAULT,
  parameter int ACC_WIDTH   = PRECISION + COEFF_WIDTH + $clog2(TAPS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [PRECISION-1:0]   x,
  input  logic                          x_valid,
  output logic                          x_ready,
  output logic signed [PRECISION-1:0]   y,
  output logic                          y_valid,
  input  logic                          coef_we,
  input  logic [$clog2(TAPS)-1:0]       coef_addr,
  input  logic signed [COEFF_WIDTH-1:0] coef_data,
  input  logic                          coef_commit,
  output logic                          busy
);

  localparam int AW = $clog2(TAPS);
  localparam int PW = PRECISION + COEFF_WIDTH;

  ff_state_t                     state;
  logic [AW-1:0]                 idx;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic signed [PRECISION-1:0]   dly [TAPS];
  logic signed [COEFF_WIDTH-1:0] coef;
  logic signed [PW-1:0]          prod;
  logic                          accept;

  assign accept = x_valid && x_ready;
  assign prod   = PW'(coef) * PW'(dly[idx]);

  iir_coef_bank #(
    .TAPS        (TAPS),
    .COEFF_WIDTH (COEFF_WIDTH),
    .COEFF_FRAC  (COEFF_FRAC)
  ) u_coef_bank (
    .clk         (clk),
    .rst         (rst),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .coef_commit (coef_commit),
    .in_idle     (state == ST_IDLE),
    .accept      (accept),
    .rd_idx      (idx),
    .rd_coef     (coef)
  );

  // Sequencer: accept a sample, run TAPS multiply-accumulate cycles, then
  // publish the rounded/saturated result with a one-cycle strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      acc     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      x_ready <= 1'b1;
      busy    <= 1'b0;
      for (int k = 0; k < TAPS; k++)
        dly[k] <= '0;
    end else begin
      y_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            dly[0] <= x;
            for (int k = 1; k < TAPS; k++)
              dly[k] <= dly[k-1];
            acc     <= '0;
            idx     <= '0;
            x_ready <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc <= acc + ACC_WIDTH'(prod);
          idx <= idx + 1'b1;
          if (idx == AW'(TAPS - 1))
            state <= ST_OUT;
        end
        ST_OUT: begin
          y       <= PRECISION'(sat_round(64'(acc), PRECISION, COEFF_FRAC));
          y_valid <= 1'b1;
          x_ready <= 1'b1;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
